pwm_multi: RTL and testbench
============================

# pwm_multi

Parametrised multi-channel PWM generator; successor to the single-channel dynamic PWM. One shared period counter drives CHANNELS compare outputs, with a programmable period, edge- or center-aligned counting, and double-buffered (shadow) duty/period/mode registers that take effect only at a period boundary, so outputs never glitch mid-period. It sits between the register/control logic and the motor, LED or servo pins.

## Interface
- WIDTH, 8: counter, period and duty width in bits.
- CHANNELS, 4: number of PWM outputs.
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run counter; low holds the counter idle and forces outputs low.
- load  in  1  one-cycle strobe; captures period, duty, center into the pending set.
- period  in  WIDTH  terminal count P.
- duty  in  CHANNELS*WIDTH  channel i compare value D_i in bits [i*WIDTH +: WIDTH].
- center  in  1  0 = edge-aligned, 1 = center-aligned.
- pwm  out  CHANNELS  registered PWM outputs.
- period_end  out  1  one-cycle pulse, registered, for each terminal cycle.
- update_done  out  1  one-cycle pulse, registered, when the pending set is copied to the active set.

## Operation
- State: cnt (WIDTH), dir (0 = up), active set {P_a, D_a[], C_a}, pending set {P_p, D_p[], C_p}, pend flag.
- Edge mode: cnt runs 0,1,…,P_a, then 0. Period = P_a+1 cycles. Terminal cycle: cnt == P_a.
- Center mode: cnt runs 0 up to P_a, then down P_a-1 to 1, then 0. dir flips at P_a and at 0. Period = 2·P_a cycles. Terminal cycle: next cnt is 0.
- P_a == 0 in either mode: cnt stays 0 and every enabled cycle is terminal.
- Compare: chan_i = (cnt < D_a[i]).
  - D_a[i] == 0 gives constant low.
  - D_a[i] > P_a gives constant high.
  - Edge mode high time = min(D_i, P+1) cycles.
  - Center mode high time = 2·D_i−1 cycles for 1 ≤ D_i ≤ P, centred on cnt == 0.
- Next pwm[i] = enable & chan_i.
- load while enabled: the pending set captures the inputs and pend is set. A second load before the boundary overwrites it (last wins). Only one update_done is produced.
- Boundary: on the terminal cycle with pend set (or with load asserted in that same cycle), the active set takes the pending or input values, pend clears, and cnt restarts at 0 with dir up.
  - load on the terminal cycle captures that cycle's inputs; they become active immediately.
  - update_done is asserted on the following cycle.
- enable low: cnt = 0, dir = up, pwm = 0, period_end = 0. load writes the active set directly and pulses update_done; pend clears.
- enable rising: counting starts at cnt = 0 on the next edge using the current active set.
- Mode change (C_a) is applied only at a boundary; cnt always restarts at 0 with dir up.
- reset dominates all other inputs. It clears cnt, dir, the active set, the pending set and pend. pwm = 0, period_end = 0, update_done = 0.

## Timing
- All outputs are registered. pwm[i] at edge n+1 reflects cnt and D_a at cycle n (one-cycle latency).
- period_end is asserted the cycle after each terminal cycle.
- With enable high, load at cycle t results in:
  - new values active from the next period's cnt = 0;
  - first pwm reflecting them one cycle later;
  - worst-case latency = one full period + 2 cycles.
- Reset and enable are sampled on the rising edge. Outputs read 0 from the first edge after reset asserts.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: reset 3 cycles with enable = 1 -> pwm = 0, period_end = 0, update_done = 0. Release with enable = 0, load P = 9, D0 = 3 -> update_done the next cycle, pwm stays 0.
- Edge mode: WIDTH = 8, P = 9, D = {0, 3, 10, 255}, enable -> 10-cycle period; ch0 always low, ch1 high 3 of 10, ch2 and ch3 always high; period_end every 10 cycles.
- Center mode: P = 4, D1 = 2 -> cnt sequence 0,1,2,3,4,3,2,1; ch1 high 3 cycles (cnt 1,0,1) of 8; period_end each 8 cycles.
- Shadow update: mid-period load D1 = 7, then load D1 = 5 two cycles later -> ch1 unchanged until the boundary, next period uses 5, exactly one update_done.
- Simultaneous load on the terminal cycle (P = 9 to P = 4) -> the next period is 5 cycles long, update_done the cycle after.
- Reset mid-period with pend set -> all outputs 0 next edge. After release and enable, with no new load, pwm stays 0 because the active duties are cleared.

Source files
------------

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator. One shared period counter with
//               edge/center alignment and shadowed period/duty/mode registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      center,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_end,
    output logic                      update_done
);

    logic [WIDTH-1:0]          r_cnt;
    logic                      r_dir_down;
    logic [WIDTH-1:0]          r_per_a;
    logic [CHANNELS*WIDTH-1:0] r_duty_a;
    logic                      r_ctr_a;
    logic [WIDTH-1:0]          r_per_p;
    logic [CHANNELS*WIDTH-1:0] r_duty_p;
    logic                      r_ctr_p;
    logic                      r_pend;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_period_end;
    logic                      r_update_done;

    logic [WIDTH-1:0]          w_cnt_nxt;
    logic                      w_dir_down_nxt;
    logic                      w_term;
    logic [CHANNELS-1:0]       w_chan;

    // Counter sequencing; cnt never exceeds P_a because it restarts at every boundary.
    always_comb begin
        w_cnt_nxt      = '0;
        w_dir_down_nxt = 1'b0;
        w_term         = 1'b0;
        if (!r_ctr_a) begin
            w_term    = (r_cnt >= r_per_a);
            w_cnt_nxt = w_term ? '0 : r_cnt + WIDTH'(1);
        end else begin
            if (r_per_a == '0) begin
                w_cnt_nxt = '0;
            end else if (!r_dir_down && (r_cnt < r_per_a)) begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end else begin
                w_cnt_nxt = r_cnt - WIDTH'(1);
            end
            w_term = (w_cnt_nxt == '0);
            if (w_term) begin
                w_dir_down_nxt = 1'b0;
            end else if (!r_dir_down && (r_cnt >= r_per_a)) begin
                w_dir_down_nxt = 1'b1;
            end else begin
                w_dir_down_nxt = r_dir_down;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_cmp
            assign w_chan[gi] = (r_cnt < r_duty_a[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_dir_down    <= 1'b0;
            r_per_a       <= '0;
            r_duty_a      <= '0;
            r_ctr_a       <= 1'b0;
            r_per_p       <= '0;
            r_duty_p      <= '0;
            r_ctr_p       <= 1'b0;
            r_pend        <= 1'b0;
            r_pwm         <= '0;
            r_period_end  <= 1'b0;
            r_update_done <= 1'b0;
        end else if (!enable) begin
            // Idle: no period is running, so a load can go straight to the active set.
            r_cnt         <= '0;
            r_dir_down    <= 1'b0;
            r_pwm         <= '0;
            r_period_end  <= 1'b0;
            r_update_done <= load;
            if (load) begin
                r_per_a  <= period;
                r_duty_a <= duty;
                r_ctr_a  <= center;
                r_pend   <= 1'b0;
            end
        end else begin
            r_pwm         <= w_chan;
            r_period_end  <= w_term;
            r_update_done <= 1'b0;
            if (w_term && (r_pend || load)) begin
                // A load on the terminal cycle wins over the older pending set.
                r_per_a       <= load ? period : r_per_p;
                r_duty_a      <= load ? duty   : r_duty_p;
                r_ctr_a       <= load ? center : r_ctr_p;
                r_pend        <= 1'b0;
                r_update_done <= 1'b1;
                r_cnt         <= '0;
                r_dir_down    <= 1'b0;
            end else begin
                r_cnt      <= w_cnt_nxt;
                r_dir_down <= w_dir_down_nxt;
                if (load) begin
                    r_per_p  <= period;
                    r_duty_p <= duty;
                    r_ctr_p  <= center;
                    r_pend   <= 1'b1;
                end
            end
        end
    end

    assign pwm         = r_pwm;
    assign period_end  = r_period_end;
    assign update_done = r_update_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi
// Description : Self-checking bench for pwm_multi against a period/phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clock = 1'b0;
    logic            reset, enable, load, center;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic [CH-1:0]   pwm;
    logic            period_end, update_done;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .period(period), .duty(duty), .center(center),
        .pwm(pwm), .period_end(period_end), .update_done(update_done)
    );

    always #5 clock = ~clock;

    // Model: position in the period (phase) plus active/pending sets.
    int m_phase, m_p, m_c, m_pend, p_p, p_c;
    int m_d[CH];
    int p_d[CH];
    logic [CH-1:0] exp_pwm;
    logic exp_pe, exp_ud;
    int n_pass = 0, n_total = 0, cyc = 0;

    task automatic step();
        logic [CH-1:0] n_pwm;
        logic n_pe, n_ud;
        int cnt, len;
        bit term;
        n_pwm = '0; n_pe = 1'b0; n_ud = 1'b0;
        if (reset) begin
            m_phase = 0; m_p = 0; m_c = 0; m_pend = 0; p_p = 0; p_c = 0;
            for (int i = 0; i < CH; i++) begin m_d[i] = 0; p_d[i] = 0; end
        end else if (!enable) begin
            m_phase = 0;
            if (load) begin
                m_p = period; m_c = center; m_pend = 0; n_ud = 1'b1;
                for (int i = 0; i < CH; i++) m_d[i] = duty[i*W +: W];
            end
        end else begin
            len  = (m_c == 0) ? m_p + 1 : ((m_p == 0) ? 1 : 2 * m_p);
            cnt  = (m_c == 0 || m_phase <= m_p) ? m_phase : 2 * m_p - m_phase;
            for (int i = 0; i < CH; i++) n_pwm[i] = (cnt < m_d[i]);
            term = (m_phase == len - 1);
            n_pe = term;
            if (term && (m_pend != 0 || load)) begin
                if (load) begin
                    m_p = period; m_c = center;
                    for (int i = 0; i < CH; i++) m_d[i] = duty[i*W +: W];
                end else begin
                    m_p = p_p; m_c = p_c;
                    for (int i = 0; i < CH; i++) m_d[i] = p_d[i];
                end
                m_pend = 0; n_ud = 1'b1; m_phase = 0;
            end else begin
                if (load) begin
                    p_p = period; p_c = center; m_pend = 1;
                    for (int i = 0; i < CH; i++) p_d[i] = duty[i*W +: W];
                end
                m_phase = term ? 0 : m_phase + 1;
            end
        end
        @(posedge clock);
        #1;
        exp_pwm = n_pwm; exp_pe = n_pe; exp_ud = n_ud;
        cyc++;
    endtask

    task automatic idle_load(input int p, input logic [CH*W-1:0] d, input logic c);
        enable = 1'b0; load = 1'b1; period = W'(p); duty = d; center = c;
        step();
        load = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b0; period = '0; duty = '0; center = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if ({pwm, period_end, update_done} !== 6'b0)
                $display("FAIL reset_out k=%0d got pwm=%b pe=%b ud=%b want 0", k, pwm, period_end, update_done);
            else n_pass++;
        end
        reset = 1'b0; enable = 1'b0; load = 1'b1; period = 8'd9; duty = {8'd0, 8'd0, 8'd0, 8'd3};
        step();
        load = 1'b0;
        n_total++;
        if ({pwm, update_done} !== 5'b00001)
            $display("FAIL idle_load got pwm=%b ud=%b want pwm=0000 ud=1", pwm, update_done);
        else n_pass++;
        step();
        n_total++;
        if ({pwm, period_end, update_done} !== 6'b0)
            $display("FAIL idle_after got pwm=%b pe=%b ud=%b want 0", pwm, period_end, update_done);
        else n_pass++;
    endtask

    task automatic test_edge();
        int hi[CH];
        int pe_cnt = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
        idle_load(9, {8'd255, 8'd10, 8'd3, 8'd0}, 1'b0);
        for (int k = 0; k < 30; k++) begin
            step();
            n_total++;
            if ({pwm, period_end, update_done} !== {exp_pwm, exp_pe, exp_ud})
                $display("FAIL edge cyc=%0d got pwm=%b pe=%b ud=%b want pwm=%b pe=%b ud=%b",
                         cyc, pwm, period_end, update_done, exp_pwm, exp_pe, exp_ud);
            else n_pass++;
            for (int i = 0; i < CH; i++) hi[i] += int'(pwm[i]);
            pe_cnt += int'(period_end);
        end
        n_total++;
        if (hi[0] != 0 || hi[1] != 9 || hi[2] != 30 || hi[3] != 30 || pe_cnt != 3)
            $display("FAIL edge_counts got hi=%0d/%0d/%0d/%0d pe=%0d want 0/9/30/30 pe=3",
                     hi[0], hi[1], hi[2], hi[3], pe_cnt);
        else n_pass++;
    endtask

    task automatic test_center();
        int hi1 = 0, pe_cnt = 0;
        idle_load(4, {8'd0, 8'd0, 8'd2, 8'd0}, 1'b1);
        for (int k = 0; k < 24; k++) begin
            step();
            n_total++;
            if ({pwm, period_end, update_done} !== {exp_pwm, exp_pe, exp_ud})
                $display("FAIL center cyc=%0d got pwm=%b pe=%b ud=%b want pwm=%b pe=%b ud=%b",
                         cyc, pwm, period_end, update_done, exp_pwm, exp_pe, exp_ud);
            else n_pass++;
            hi1 += int'(pwm[1]);
            pe_cnt += int'(period_end);
        end
        n_total++;
        if (hi1 != 9 || pe_cnt != 3)
            $display("FAIL center_counts got ch1_hi=%0d pe=%0d want 9 and 3", hi1, pe_cnt);
        else n_pass++;
    endtask

    task automatic test_shadow();
        int hi_old = 0, hi_new = 0, ud_cnt = 0;
        idle_load(9, {8'd0, 8'd0, 8'd3, 8'd0}, 1'b0);
        for (int k = 0; k < 20; k++) begin
            load = (k == 3 || k == 5);
            duty = (k == 3) ? {8'd0, 8'd0, 8'd7, 8'd0} : {8'd0, 8'd0, 8'd5, 8'd0};
            step();
            load = 1'b0;
            n_total++;
            if ({pwm, period_end, update_done} !== {exp_pwm, exp_pe, exp_ud})
                $display("FAIL shadow cyc=%0d got pwm=%b pe=%b ud=%b want pwm=%b pe=%b ud=%b",
                         cyc, pwm, period_end, update_done, exp_pwm, exp_pe, exp_ud);
            else n_pass++;
            if (k < 10) hi_old += int'(pwm[1]);
            else        hi_new += int'(pwm[1]);
            ud_cnt += int'(update_done);
        end
        n_total++;
        if (hi_old != 3 || hi_new != 5 || ud_cnt != 1)
            $display("FAIL shadow_counts got old_hi=%0d new_hi=%0d ud=%0d want 3 5 1", hi_old, hi_new, ud_cnt);
        else n_pass++;
    endtask

    task automatic test_terminal_load();
        int pe_cnt = 0;
        idle_load(9, {8'd0, 8'd0, 8'd3, 8'd0}, 1'b0);
        for (int k = 0; k < 9; k++) step();
        load = 1'b1; period = 8'd4;
        step();
        load = 1'b0;
        n_total++;
        if ({period_end, update_done} !== 2'b11)
            $display("FAIL term_load got pe=%b ud=%b want 1 1", period_end, update_done);
        else n_pass++;
        for (int k = 0; k < 15; k++) begin
            step();
            n_total++;
            if ({pwm, period_end, update_done} !== {exp_pwm, exp_pe, exp_ud})
                $display("FAIL term_run cyc=%0d got pwm=%b pe=%b ud=%b want pwm=%b pe=%b ud=%b",
                         cyc, pwm, period_end, update_done, exp_pwm, exp_pe, exp_ud);
            else n_pass++;
            pe_cnt += int'(period_end);
        end
        n_total++;
        if (pe_cnt != 3)
            $display("FAIL term_period got pe=%0d want 3", pe_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle_load(9, {8'd5, 8'd5, 8'd5, 8'd5}, 1'b0);
        for (int k = 0; k < 3; k++) step();
        load = 1'b1; duty = {8'd7, 8'd7, 8'd7, 8'd7};
        step();
        load = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if ({pwm, period_end, update_done} !== 6'b0)
            $display("FAIL reset_mid got pwm=%b pe=%b ud=%b want 0", pwm, period_end, update_done);
        else n_pass++;
        for (int k = 0; k < 25; k++) begin
            step();
            n_total++;
            if (pwm !== 4'b0 || update_done !== 1'b0)
                $display("FAIL reset_cleared cyc=%0d got pwm=%b ud=%b want 0", cyc, pwm, update_done);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 19) != 0);
            load   = ($urandom_range(0, 9) == 0);
            center = 1'($urandom_range(0, 1));
            period = W'($urandom_range(0, 12));
            for (int i = 0; i < CH; i++) duty[i*W +: W] = W'($urandom_range(0, 15));
            step();
            n_total++;
            if ({pwm, period_end, update_done} !== {exp_pwm, exp_pe, exp_ud})
                $display("FAIL random cyc=%0d got pwm=%b pe=%b ud=%b want pwm=%b pe=%b ud=%b",
                         cyc, pwm, period_end, update_done, exp_pwm, exp_pe, exp_ud);
            else n_pass++;
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_terminal_load();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
